axi_burst_writer: RTL and testbench

AXI_BURST_WRITER -- requirements
Module: axi_burst_writer

---
 rtl/axi_burst_writer.sv | 182 ++++++++++++++++++
 tb/tb_axi_burst_writer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_writer.sv
// axi_burst_writer: turns a (start address, word count) command plus a data
// stream into a sequence of AXI4 INCR write bursts, one burst in flight at a time.
module axi_burst_writer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned WRITE_ID   = 0
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // command
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [15:0]               cmd_words,
    // data stream
    input  logic [DATA_WIDTH-1:0]     din,
    input  logic                      din_valid,
    output logic                      din_ready,
    // AXI4 write address
    output logic [ID_WIDTH-1:0]       m_awid,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [7:0]                m_awlen,
    output logic [2:0]                m_awsize,
    output logic [1:0]                m_awburst,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    // AXI4 write data
    output logic [ID_WIDTH-1:0]       m_wid,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wlast,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    // AXI4 write response
    input  logic [ID_WIDTH-1:0]       m_bid,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    // status
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  AW_SIZE    = 3'($clog2(STRB_WIDTH));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [15:0]           remaining_q, remaining_d;
    logic [7:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  ready_en_q;
    logic [8:0]            burst_beats;
    logic                  w_hs;

    // The burst response ID is not used: only one burst is ever outstanding.
    logic unused_ok;
    assign unused_ok = ^m_bid;

    // Beats in the next burst: whatever is left, capped at MAX_BURST.
    always_comb begin
        if (remaining_q > 16'(MAX_BURST)) begin
            burst_beats = 9'(MAX_BURST);
        end else begin
            burst_beats = 9'(remaining_q);
        end
    end

    // Output decode; AW fields come straight from registers so they hold until accepted.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && ready_en_q;
        m_awid    = ID_WIDTH'(WRITE_ID);
        m_awaddr  = cur_addr_q;
        m_awlen   = 8'(burst_beats - 9'd1);
        m_awsize  = AW_SIZE;
        m_awburst = 2'b01;
        m_awvalid = (state_q == ST_ADDR);
        m_wid     = ID_WIDTH'(WRITE_ID);
        m_wdata   = din;
        m_wstrb   = '1;
        m_wlast   = (state_q == ST_DATA) && (beat_q == 8'd0);
        m_wvalid  = (state_q == ST_DATA) && din_valid;
        din_ready = (state_q == ST_DATA) && m_wready;
        m_bready  = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        err       = err_q;
        w_hs      = (state_q == ST_DATA) && din_valid && m_wready;
    end

    // Next-state logic for the command/burst sequencer.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        beat_d      = beat_q;
        err_d       = err_q;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cur_addr_d  = cmd_addr;
                    remaining_d = cmd_words;
                    err_d       = 1'b0;
                    if (cmd_words == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (m_awready) begin
                    beat_d  = m_awlen;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_hs) begin
                    beat_d      = beat_q - 8'd1;
                    remaining_d = remaining_q - 16'd1;
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(STRB_WIDTH);
                    if (beat_q == 8'd0) begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (m_bvalid) begin
                    if (m_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                    if (remaining_q == 16'd0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset abandons any burst in progress.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    // Hold off command acceptance until the first clock after reset release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Randomized bench for axi_burst_writer: acts as the data source and AXI slave,
// records every AW/W/B transfer and compares against bursts derived from the command.
module tb_axi_burst_writer;

    localparam int MAXB = 16;
    localparam int BPW  = 4;   // bytes per word

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd_addr;
    logic [15:0] cmd_words;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [3:0]  m_awid;
    logic [11:0] m_awaddr;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic        m_awvalid;
    logic        m_awready;
    logic [3:0]  m_wid;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast;
    logic        m_wvalid;
    logic        m_wready;
    logic [3:0]  m_bid;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic        busy;
    logic        done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    logic [31:0] w_data_q[$];
    logic        w_last_q[$];

    axi_burst_writer dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_words (cmd_words),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .m_awid    (m_awid),
        .m_awaddr  (m_awaddr),
        .m_awlen   (m_awlen),
        .m_awsize  (m_awsize),
        .m_awburst (m_awburst),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wid     (m_wid),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wlast   (m_wlast),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bid     (m_bid),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One command against a slave that is always ready (rnd=0) or randomly stalls.
    // bad_burst selects which burst gets SLVERR (-1 for none).
    task automatic run_cmd(input logic [11:0] addr, input int n, input int bad_burst,
                           input bit rnd);
        logic [31:0] src[$];
        int          cyc, acc_cyc, done_cyc, done_cnt, din_idx, bcnt, aw_bad, nb, wi;
        bit          accepted, pend_b, fin, aw_hold;
        logic [11:0] held_addr;
        logic [7:0]  held_len;
        logic [11:0] exp_addr;
        int          exp_len;

        aw_addr_q.delete();
        aw_len_q.delete();
        w_data_q.delete();
        w_last_q.delete();
        for (int i = 0; i < n; i++) src.push_back($urandom);
        cyc = 0; acc_cyc = 0; done_cyc = 0; done_cnt = 0; din_idx = 0; bcnt = 0; aw_bad = 0;
        accepted = 0; pend_b = 0; fin = 0; aw_hold = 0; held_addr = '0; held_len = '0;

        while (!fin && cyc < 3000) begin
            @(negedge aclk);
            cmd_valid = !accepted;
            cmd_addr  = addr;
            cmd_words = 16'(n);
            din_valid = (din_idx < n) && (!rnd || $urandom_range(0, 3) != 0);
            din       = (din_idx < n) ? src[din_idx] : 32'h0;
            m_awready = !rnd || $urandom_range(0, 2) != 0;
            m_wready  = !rnd || $urandom_range(0, 3) != 0;
            m_bvalid  = pend_b && (!rnd || $urandom_range(0, 2) != 0);
            m_bresp   = (bcnt == bad_burst) ? 2'b10 : 2'b00;
            m_bid     = 4'($urandom);
            #1;
            if (accepted && done) begin
                done_cnt++;
                if (done_cnt == 1) done_cyc = cyc;
            end
            if (accepted && cyc == acc_cyc + 1) begin
                check_eq("err_clear_on_accept", err, 0);
                check_eq("busy_after_accept", busy, (n != 0));
            end
            if (!accepted && cmd_valid && cmd_ready) begin
                accepted = 1;
                acc_cyc  = cyc;
            end
            if (aw_hold && !(m_awvalid && m_awaddr == held_addr && m_awlen == held_len))
                aw_bad++;
            aw_hold   = m_awvalid && !m_awready;
            held_addr = m_awaddr;
            held_len  = m_awlen;
            if (m_awvalid && m_awready) begin
                aw_addr_q.push_back(m_awaddr);
                aw_len_q.push_back(m_awlen);
                check_eq("awsize", m_awsize, 2);
                check_eq("awburst", m_awburst, 1);
                check_eq("awid", m_awid, 0);
            end
            if (m_wvalid && m_wready) begin
                w_data_q.push_back(m_wdata);
                w_last_q.push_back(m_wlast);
                if (!din_ready) aw_bad++;
                din_idx++;
                if (m_wlast) pend_b = 1;
            end
            if (m_bvalid && m_bready) begin
                pend_b = 0;
                bcnt++;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 4) fin = 1;
            cyc++;
        end
        if (!fin) check_eq("cmd_timeout", 0, 1);

        nb = (n + MAXB - 1) / MAXB;
        check_eq("done_count", done_cnt, 1);
        check_eq("aw_count", aw_addr_q.size(), nb);
        check_eq("aw_stable_and_w_ready", aw_bad, 0);
        if (n == 0) check_eq("zero_done_latency", done_cyc - acc_cyc, 1);
        for (int b = 0; b < nb && b < aw_addr_q.size(); b++) begin
            exp_addr = 12'(int'(addr) + b * MAXB * BPW);
            exp_len  = ((n - b * MAXB) > MAXB) ? MAXB : (n - b * MAXB);
            check_eq("awaddr", aw_addr_q[b], exp_addr);
            check_eq("awlen", aw_len_q[b], exp_len - 1);
        end
        check_eq("w_count", w_data_q.size(), n);
        wi = (w_data_q.size() < n) ? w_data_q.size() : n;
        for (int i = 0; i < wi; i++) begin
            check_eq("wdata", w_data_q[i], src[i]);
            check_eq("wlast", w_last_q[i], (i % MAXB == MAXB - 1) || (i == n - 1));
        end
        check_eq("err_final", err, (bad_burst >= 0 && bad_burst < nb));
        check_eq("busy_final", busy, 0);
    endtask

    initial begin
        int wb;
        bit reached;
        aresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_words = '0;
        din       = '0;
        din_valid = 1'b0;
        m_awready = 1'b0;
        m_wready  = 1'b0;
        m_bid     = '0;
        m_bresp   = '0;
        m_bvalid  = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check_eq("rst_awvalid", m_awvalid, 0);
        check_eq("rst_wvalid", m_wvalid, 0);
        check_eq("rst_bready", m_bready, 0);
        check_eq("rst_din_ready", din_ready, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check_eq("cmd_ready_after_rst", cmd_ready, 1);

        run_cmd(12'h100, 4, -1, 0);
        run_cmd(12'h000, 37, -1, 0);
        for (int t = 0; t < 4; t++)
            run_cmd(12'($urandom_range(0, 1023) * 4), int'($urandom_range(1, 70)), -1, 1);
        run_cmd(12'h300, 40, 1, 1);
        run_cmd(12'h040, 3, -1, 0);
        run_cmd(12'h080, 0, -1, 0);
        run_cmd(12'hFF0, 20, -1, 1);

        // Reset while the second data beat of a burst is pending.
        wb = 0;
        reached = 0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge aclk);
            cmd_valid = (c == 0);
            cmd_addr  = 12'h200;
            cmd_words = 16'd20;
            din       = $urandom;
            din_valid = 1'b1;
            m_awready = 1'b1;
            m_wready  = 1'b1;
            m_bvalid  = 1'b0;
            #1;
            if (m_wvalid && m_wready) wb++;
            if (wb == 1) reached = 1;
        end
        check_eq("rst_mid_reached", reached, 1);
        @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check_eq("mid_rst_awvalid", m_awvalid, 0);
        check_eq("mid_rst_wvalid", m_wvalid, 0);
        check_eq("mid_rst_din_ready", din_ready, 0);
        check_eq("mid_rst_bready", m_bready, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", done, 0);
        @(negedge aclk);
        aresetn   = 1'b1;
        din_valid = 1'b0;
        cmd_valid = 1'b0;
        @(negedge aclk);
        #1;
        check_eq("cmd_ready_after_mid_rst", cmd_ready, 1);
        run_cmd(12'h500, 10, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
